// File: rtl/morse_pkg.sv
// morse_pkg: shared state encodings, element encoding and tick helper for the Morse playback sequencer
package morse_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_TONE  = 3'd2;
    localparam logic [2:0] S_EGAP  = 3'd3;
    localparam logic [2:0] S_CGAP  = 3'd4;
    localparam logic [2:0] S_SPACE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    typedef enum logic {DOT = 1'b0, DASH = 1'b1} elem_e;
    localparam logic [2:0] SPACE_LEN = 3'd0;
    localparam int MAX_ELEMS = 5;
    // Countdown reload value: a duration of 0 behaves as 1, and 3 bits cap it at 8
    function automatic logic [2:0] ticks_m1(input int t);
        return (t <= 1) ? 3'd0 : (t >= 8 ? 3'd7 : 3'(t - 1));
    endfunction
endpackage

// File: rtl/elem_timer.sv
// elem_timer: 3-bit countdown loaded on state entry, flags zero when the current state has expired
module elem_timer (
    input  logic       clk_s02,
    input  logic       rst,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    output logic       zero_o
);
    logic [2:0] cnt_q, cnt_d;
    always_comb cnt_d = load_i ? load_val_i : (cnt_q != 3'd0 ? cnt_q - 3'd1 : cnt_q);
    always_ff @(posedge clk_s02 or posedge rst) begin
        if (rst) cnt_q <= 3'd0;
        else     cnt_q <= cnt_d;
    end
    assign zero_o = (cnt_q == 3'd0);
endmodule

// File: rtl/morse_playback_sequencer.sv
// morse_playback_sequencer: plays a buffer of Morse characters as timed tone/silence on a buzzer enable
module morse_playback_sequencer
    import morse_pkg::*;
#(
    parameter int MAX_CHARS  = 8,
    parameter int DOT_TICKS  = 1,
    parameter int DASH_TICKS = 3,
    parameter int EGAP_TICKS = 1,
    parameter int CGAP_TICKS = 3,
    parameter int WGAP_TICKS = 7
) (
    input  logic       clk_s02,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] char_count,
    input  logic [4:0] sym_bits,
    input  logic [2:0] sym_len,
    output logic [2:0] rd_idx,
    output logic       tone,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);
    logic [2:0] state_q, state_d, idx_q, idx_d, left_q, left_d, len_eff, load_val;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] shift_q, shift_d;
    logic       zero, last_char;
    elem_e      nxt_elem;

    assign len_eff   = (sym_len > 3'(MAX_ELEMS)) ? 3'(MAX_ELEMS) : sym_len;
    assign last_char = ({1'b0, idx_q} + 4'd1) >= cnt_q;
    // The element about to sound comes straight from the slot on FETCH, else from the shifter
    assign nxt_elem  = elem_e'(state_q == S_FETCH ? sym_bits[4] : shift_q[4]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        left_d  = left_q;
        case (state_q)
            S_IDLE: if (start && char_count != 4'd0) begin
                state_d = S_FETCH;
                idx_d   = 3'd0;
                cnt_d   = (char_count > 4'(MAX_CHARS)) ? 4'(MAX_CHARS) : char_count;
            end
            S_FETCH: begin
                shift_d = sym_bits;
                left_d  = len_eff;
                state_d = (len_eff == SPACE_LEN) ? S_SPACE : S_TONE;
            end
            S_TONE: if (zero) begin
                if (left_q > 3'd1) begin
                    state_d = S_EGAP;
                    shift_d = shift_q << 1;
                    left_d  = left_q - 3'd1;
                end else state_d = last_char ? S_DONE : S_CGAP;
            end
            S_EGAP:  if (zero) state_d = S_TONE;
            S_SPACE: if (zero) state_d = last_char ? S_DONE : S_CGAP;
            S_CGAP: if (zero) begin
                state_d = S_FETCH;
                idx_d   = idx_q + 3'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = 3'd0;
        end
    end

    always_comb
        load_val = (state_d == S_TONE)  ? (nxt_elem == DASH ? ticks_m1(DASH_TICKS) : ticks_m1(DOT_TICKS)) :
                   (state_d == S_EGAP)  ? ticks_m1(EGAP_TICKS) :
                   (state_d == S_CGAP)  ? ticks_m1(CGAP_TICKS) :
                   (state_d == S_SPACE) ? ticks_m1(WGAP_TICKS) : 3'd0;

    elem_timer u_timer (
        .clk_s02   (clk_s02),
        .rst       (rst),
        .load_i    (state_d != state_q),
        .load_val_i(load_val),
        .zero_o    (zero)
    );

    always_ff @(posedge clk_s02 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            shift_q <= 5'd0;
            left_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            left_q  <= left_d;
        end
    end

    assign rd_idx    = idx_q;
    assign tone      = (state_q == S_TONE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;
endmodule

// File: tb/tb_morse_playback_sequencer.sv
// tb_morse_playback_sequencer: directed and randomized playback checked against a timeline model
module tb_morse_playback_sequencer;
    localparam int DOT = 1, DASH = 3, EG = 1, CG = 3, WG = 7, MAXC = 8;

    typedef struct {
        bit t;
        bit b;
        bit d;
        int idx;
    } exp_t;

    logic       clk_s02 = 1'b0;
    logic       rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [3:0] char_count = 4'd0;
    logic [4:0] sym_bits;
    logic [2:0] sym_len, rd_idx, state_dbg;
    logic       tone, busy, done;
    logic [4:0] bits_m [8];
    logic [2:0] len_m [8];
    int         n_cmp = 0, n_bad = 0;

    assign sym_bits = bits_m[rd_idx];
    assign sym_len  = len_m[rd_idx];

    always #5 clk_s02 = ~clk_s02;

    morse_playback_sequencer dut (
        .clk_s02(clk_s02), .rst(rst), .start(start), .abort(abort),
        .char_count(char_count), .sym_bits(sym_bits), .sym_len(sym_len),
        .rd_idx(rd_idx), .tone(tone), .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    task automatic tick();
        @(posedge clk_s02);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_tone"}, {7'd0, tone}, 8'd0);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
        chk({tag, "_idx"}, {5'd0, rd_idx}, 8'd0);
    endtask

    // Expected per-cycle outputs after the start edge, straight from the timing rules
    task automatic build(input int cnt, output exp_t q[$]);
        int n, l;
        q = {};
        n = (cnt > MAXC) ? MAXC : cnt;
        for (int i = 0; i < n; i++) begin
            q.push_back('{0, 1, 0, i});
            l = (len_m[i] > 5) ? 5 : int'(len_m[i]);
            if (l == 0) begin
                for (int k = 0; k < WG; k++) q.push_back('{0, 1, 0, i});
            end else begin
                for (int e = 0; e < l; e++) begin
                    for (int k = 0; k < (bits_m[i][4-e] ? DASH : DOT); k++) q.push_back('{1, 1, 0, i});
                    if (e < l - 1) for (int k = 0; k < EG; k++) q.push_back('{0, 1, 0, i});
                end
            end
            if (i < n - 1) for (int k = 0; k < CG; k++) q.push_back('{0, 1, 0, i});
        end
        q.push_back('{0, 0, 1, -1});
        q.push_back('{0, 0, 0, 0});
    endtask

    task automatic play(input string tag, input int cnt, input bit noisy);
        exp_t q[$];
        build(cnt, q);
        char_count = 4'(cnt);
        start = 1'b1;
        for (int k = 0; k < q.size(); k++) begin
            tick();
            start = 1'b0;
            chk($sformatf("%s_c%0d_tone", tag, k + 1), {7'd0, tone}, {7'd0, q[k].t});
            chk($sformatf("%s_c%0d_busy", tag, k + 1), {7'd0, busy}, {7'd0, q[k].b});
            chk($sformatf("%s_c%0d_done", tag, k + 1), {7'd0, done}, {7'd0, q[k].d});
            if (q[k].idx >= 0) chk($sformatf("%s_c%0d_idx", tag, k + 1), {5'd0, rd_idx}, 8'(q[k].idx));
            if (noisy && k < q.size() - 1) begin
                start = 1'($urandom);
                char_count = 4'($urandom);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            bits_m[i] = 5'd0;
            len_m[i] = 3'd0;
        end
        #12;
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("post_reset");

        bits_m[0] = 5'b01000; len_m[0] = 3'd2;
        play("A", 1, 0);

        bits_m[0] = 5'b00000; len_m[0] = 3'd1;
        bits_m[1] = 5'b10000; len_m[1] = 3'd1;
        play("ET", 2, 0);

        len_m[0] = 3'd0;
        play("space", 1, 0);

        char_count = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk_idle("count0");
            tick();
        end

        bits_m[0] = 5'b10000; len_m[0] = 3'd1;
        char_count = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_pre_tone", {7'd0, tone}, 8'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_idle("abort");
            tick();
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk_idle("abort_start");
        play("after_abort", 1, 0);

        for (int i = 0; i < 8; i++) begin
            bits_m[i] = 5'($urandom);
            len_m[i] = 3'($urandom_range(0, 3));
        end
        play("cnt12", 12, 0);

        bits_m[0] = 5'b10000; len_m[0] = 3'd1;
        char_count = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1 chk_idle("async_rst");
        rst = 1'b0;
        play("after_rst", 1, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                bits_m[i] = 5'($urandom);
                len_m[i] = 3'($urandom_range(0, 7));
            end
            play($sformatf("rnd%0d", r), $urandom_range(1, 10), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/morse_playback_sequencer.md
MORSE_PLAYBACK_SEQUENCER -- requirements
Module: morse_playback_sequencer

Interface
REQ-001 SHALL have parameter MAX_CHARS, default 8, number of character slots in the playback buffer.
REQ-002 SHALL have parameter DOT_TICKS, default 1, tone length of a dot in clk_s02 cycles.
REQ-003 SHALL have parameter DASH_TICKS, default 3, tone length of a dash in clk_s02 cycles.
REQ-004 SHALL have parameter EGAP_TICKS, default 1, silence between elements of one character.
REQ-005 SHALL have parameter CGAP_TICKS, default 3, silence between characters.
REQ-006 SHALL have parameter WGAP_TICKS, default 7, silence for a space character.
REQ-007 SHALL use reset rst, asynchronous, active-high; clock clk_s02.
REQ-008 Ports: clk_s02 in 1, playback clock; rst in 1, async reset; start in 1, single-cycle playback request; abort in 1, stop playback; char_count in 4, number of stored characters; sym_bits in 5, element pattern of slot rd_idx, bit4 = first element, 1 = dash, 0 = dot; sym_len in 3, element count of slot rd_idx, 0 = space.
REQ-009 Ports: rd_idx out 3, slot being fetched/played; tone out 1, buzzer enable; busy out 1, playback in progress; done out 1, single-cycle completion pulse; state_dbg out 3, current state encoding for LEDs.

Function
REQ-010 SHALL implement states IDLE, FETCH, TONE, EGAP, CGAP, SPACE, DONE; all outputs Moore-decoded from registered state.
REQ-011 IDLE: start=1 with char_count>=1 -> FETCH next cycle, rd_idx=0; start with char_count=0 -> stay IDLE, no done.
REQ-012 char_count > MAX_CHARS SHALL be treated as MAX_CHARS; char_count is sampled into a register on accepted start and ignored thereafter.
REQ-013 FETCH lasts exactly 1 cycle; sym_bits/sym_len (combinational read of rd_idx) SHALL be latched at its end.
REQ-014 sym_len > 5 SHALL be clamped to 5; sym_len = 0 -> SPACE for WGAP_TICKS cycles, else TONE for first element.
REQ-015 TONE SHALL last DASH_TICKS cycles for a 1 element, DOT_TICKS for a 0 element; tone=1 exactly in TONE cycles.
REQ-016 After a non-last element TONE -> EGAP (EGAP_TICKS cycles) -> TONE of next element, elements consumed MSB first.
REQ-017 After last element (or SPACE) with more characters remaining -> CGAP (CGAP_TICKS cycles) -> FETCH with rd_idx incremented by 1.
REQ-018 After last element (or SPACE) of the last character -> DONE directly (no trailing gap).
REQ-019 DONE lasts 1 cycle with done=1, then IDLE; rd_idx returns to 0 in IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE and DONE.
REQ-021 start while not in IDLE SHALL be ignored.
REQ-022 abort=1 in any state SHALL force IDLE on the next edge (tone=0, busy=0, no done pulse); abort and start together in IDLE: abort wins.
REQ-023 Tick counter SHALL be 3 bits wide, load (ticks-1) on state entry, advance state at zero; parameters of 0 treated as 1.

Reset
REQ-024 On rst: state=IDLE, rd_idx=0, tone=0, busy=0, done=0, internal counters and latched symbol cleared.
REQ-025 rst asserted mid-TONE SHALL drop tone within the reset assertion, no clock required.

Structure
REQ-026 State enum, element encoding (DOT=0, DASH=1), SPACE_LEN=0 and MAX_ELEMS=5 SHALL live in shared package morse_pkg.
REQ-027 Tick countdown SHALL be a sub-module elem_timer (load, count, zero flag); FSM and element shifter stay in the top.

Verification
REQ-028 char_count=1, sym_len=2, sym_bits=01000 ("A"), start at cycle 0 -> FETCH c1, tone=1 c2, 0 c3, 1 c4-c6, done=1 c7, IDLE c8.
REQ-029 char_count=2, slots "E"(len1,00000) and "T"(len1,10000) -> tone c2, silence c3-c5, FETCH c6 rd_idx=1, tone c7-c9, done c10.
REQ-030 char_count=1, sym_len=0 -> tone never 1, busy 7 cycles in SPACE, done pulse after.
REQ-031 abort asserted in second TONE cycle of a dash -> next edge IDLE, tone=0, busy=0, done never pulses; new start then replays from rd_idx=0.
REQ-032 start with char_count=0 -> busy and done stay 0; char_count=12 -> exactly 8 FETCH states before done.
REQ-033 rst pulsed asynchronously mid-TONE -> tone=0 immediately, all outputs at reset values, start accepted on first edge after release.
